// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared definitions for the hazard/stall controller:
//   - FSM state encoding (IDLE, LU_STALL, MD_BUSY)
//   - register-zero constant and register-number width
//   - shadow-pipeline entry layouts
//   - mult/div latency counter width
// -----------------------------------------------------------------------------
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned MD_CNT_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MD_BUSY  = 2'd2
    } state_t;

    // EX entry: the load flag is what load-use detection looks at.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } shadow_entry_t;

    // MEM/WB entries: forwarding covers loads from here on, so only the
    // destination is tracked for the pending-write mask.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } inflight_entry_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// -----------------------------------------------------------------------------
// hazard_shadow_pipe
// Three-stage shadow of the destination registers in flight (EX, MEM, WB).
// A bubble kills the entry entering EX; register 0 is never tracked.
// Ports:
//   iClk, iRst_n     clock, asynchronous active-low reset
//   iBubble          NOP is being forced into ID/EX this cycle
//   iRegWrite        ID instruction writes iRegRd
//   iRegRd           ID destination register
//   iMemRead         ID instruction is a load
//   oExEntry         current EX entry {valid, rd, is_load}
//   oPendingMask     bit n set when register n has a valid write in flight
// -----------------------------------------------------------------------------
module hazard_shadow_pipe
    import hazard_stall_unit_pkg::*;
(
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iBubble,
    input  logic                iRegWrite,
    input  logic [REG_W-1:0]    iRegRd,
    input  logic                iMemRead,
    output shadow_entry_t       oExEntry,
    output logic [NUM_REGS-1:0] oPendingMask
);

    shadow_entry_t   r_ex;
    inflight_entry_t r_mem;
    inflight_entry_t r_wb;

    // NOTE: non-blocking assignments make all three stages shift on the same
    // edge from their pre-edge values; blocking would collapse the pipeline.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb       <= r_mem;
            r_mem      <= '{valid: r_ex.valid, rd: r_ex.rd};
            r_ex.valid <= iRegWrite && (iRegRd != REG_ZERO) && !iBubble;
            r_ex.rd    <= iRegRd;
            r_ex.is_load <= iMemRead;
        end
    end

    // NOTE: the mask gets its default before the conditional sets, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        oPendingMask = '0;
        if (r_ex.valid)  oPendingMask[r_ex.rd]  = 1'b1;
        if (r_mem.valid) oPendingMask[r_mem.rd] = 1'b1;
        if (r_wb.valid)  oPendingMask[r_wb.rd]  = 1'b1;
    end

    assign oExEntry = r_ex;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Front-end hazard controller for the 5-stage core. Stalls on load-use,
// flushes on a taken branch, and (optionally) stalls HI/LO users while a
// multi-cycle mult/div is in progress.
//
// Configuration macro: HAZARD_MULDIV_EN
//   defined   -> MULDIV_LAT parameter, iIdMulDiv/iIdHiLoUse ports, latency
//                counter and MD_BUSY state are present
//   undefined -> mult/div treated as single-cycle; FSM is IDLE/LU_STALL only
//
// Ports:
//   iClk, iRst_n             clock, asynchronous active-low reset
//   iIdRegRs, iIdRegRt       ID source registers
//   iIdUsesRs, iIdUsesRt     ID instruction reads rs / rt
//   iIdRegRd, iIdRegWrite    ID destination register and its write enable
//   iIdMemRead               ID instruction is a load
//   iIdMulDiv, iIdHiLoUse    mult/div issue, HI/LO consumer (macro only)
//   iExBranchTaken           branch/jump resolved taken in EX
//   oStall                   hold PC and IF/ID
//   oBubble                  force NOP into ID/EX
//   oFlush                   clear IF/ID
//   oPendingMask             registers with a valid write in EX/MEM/WB
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
`ifdef HAZARD_MULDIV_EN
#(
    parameter int unsigned MULDIV_LAT = 4
)
`endif
(
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic [REG_W-1:0]    iIdRegRs,
    input  logic [REG_W-1:0]    iIdRegRt,
    input  logic                iIdUsesRs,
    input  logic                iIdUsesRt,
    input  logic [REG_W-1:0]    iIdRegRd,
    input  logic                iIdRegWrite,
    input  logic                iIdMemRead,
`ifdef HAZARD_MULDIV_EN
    input  logic                iIdMulDiv,
    input  logic                iIdHiLoUse,
`endif
    input  logic                iExBranchTaken,
    output logic                oStall,
    output logic                oBubble,
    output logic                oFlush,
    output logic [NUM_REGS-1:0] oPendingMask
);

    shadow_entry_t w_ex_entry;
    logic          w_lu;
    logic          w_md_stall;
    state_t        r_state;

    hazard_shadow_pipe u_shadow (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iBubble      (oBubble),
        .iRegWrite    (iIdRegWrite),
        .iRegRd       (iIdRegRd),
        .iMemRead     (iIdMemRead),
        .oExEntry     (w_ex_entry),
        .oPendingMask (oPendingMask)
    );

`ifdef HAZARD_MULDIV_EN
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_LAT - 1);

    logic [MD_CNT_W-1:0] r_md_cnt;
    logic                w_md_issue;

    // A mult/div only issues when it actually leaves ID this cycle.
    assign w_md_issue = iIdMulDiv && !oStall && !oFlush;

    // The counter keeps running through a branch flush: the unit in EX has
    // already started and HI/LO stays busy regardless.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_md_cnt <= '0;
        end else if (w_md_issue) begin
            r_md_cnt <= MD_LOAD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        w_lu = w_ex_entry.valid && w_ex_entry.is_load &&
               ((iIdUsesRs && (w_ex_entry.rd == iIdRegRs)) ||
                (iIdUsesRt && (w_ex_entry.rd == iIdRegRt)));
        w_md_stall = 1'b0;
`ifdef HAZARD_MULDIV_EN
        w_md_stall = iIdHiLoUse && (r_md_cnt != '0);
`endif
        // Outputs are qualified with reset so the front end sees a clean,
        // quiet controller the instant reset asserts, whatever ID presents.
        // A taken branch wins: the stalled instruction is being discarded.
        oFlush  = iRst_n && iExBranchTaken;
        oStall  = iRst_n && !iExBranchTaken && (w_lu || w_md_stall);
        oBubble = iRst_n && (iExBranchTaken || w_lu || w_md_stall);
    end

    // Diagnostic state only; hazard outputs come from the terms above.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lu && !iExBranchTaken) begin
                        r_state <= ST_LU_STALL;
                    end
`ifdef HAZARD_MULDIV_EN
                    else if (w_md_issue) begin
                        r_state <= ST_MD_BUSY;
                    end
`endif
                end
                ST_LU_STALL: r_state <= ST_IDLE;
`ifdef HAZARD_MULDIV_EN
                // Leave when the counter reaches 0 on this edge.
                ST_MD_BUSY: begin
                    if (r_md_cnt <= MD_CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
